// File: rtl/time_display_select.sv
// Display time-source selector.
// Picks one of NUM_SRC packed time words and registers it onto the display bus.
// A non-default selection falls back to source 0 after TIMEOUT idle ticks.
// Also generates the edit-mode blink phase.
module time_display_select #(
    parameter int unsigned TIME_W  = 14,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TIMEOUT = 10,
    localparam int unsigned SEL_W  = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [NUM_SRC*TIME_W-1:0] src_time,
    input  logic                      sel_valid,
    input  logic [SEL_W-1:0]          sel_idx,
    input  logic                      activity,
    input  logic                      blink_en,
    output logic [TIME_W-1:0]         chosen_time,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      blank,
    output logic                      reverted
);

    // Counter only ever needs to reach TIMEOUT; keep at least one bit so the
    // TIMEOUT=0 build still has a legal (constant-zero) register.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          REVERT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    if ((NUM_SRC < 2) || (NUM_SRC > 16)) begin : g_bad_num_src
        $error("time_display_select: NUM_SRC must be in 2..16");
    end

    typedef enum logic {
        StDefault,
        StAlt
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TIME_W-1:0]   chosen_q, chosen_d;
    logic                blank_q, blank_d;
    logic                reverted_q, reverted_d;

    logic                sel_legal;
    logic                sel_to_default;
    logic                timeout_hit;

    // Requests outside the populated source range are dropped entirely, so
    // they neither change state nor count as user activity.
    always_comb begin
        sel_legal      = sel_valid && (32'(sel_idx) < NUM_SRC);
        sel_to_default = (sel_idx == '0);
        timeout_hit    = REVERT_EN && tick && (cnt_q == CNT_LAST);
    end

    // Selection FSM next state; priority is legal select, then activity, then tick.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        reverted_d = 1'b0;

        unique case (state_q)
            StDefault: begin
                sel_d = '0;
                cnt_d = '0;
                if (sel_legal && !sel_to_default) begin
                    state_d = StAlt;
                    sel_d   = sel_idx;
                end
            end

            StAlt: begin
                if (sel_legal) begin
                    cnt_d = '0;
                    if (sel_to_default) begin
                        // Explicit return is not an auto-revert: no pulse.
                        state_d = StDefault;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_idx;
                    end
                end else if (activity) begin
                    cnt_d = '0;
                end else if (timeout_hit) begin
                    state_d    = StDefault;
                    sel_d      = '0;
                    cnt_d      = '0;
                    reverted_d = 1'b1;
                end else if (tick && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StDefault;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath mux uses the next selection so a new choice shows one cycle
    // after the request, and source contents are always tracked live.
    always_comb begin
        chosen_d = src_time[32'(sel_d) * TIME_W +: TIME_W];
    end

    // Blink phase: toggles per tick while enabled, parked at 0 otherwise.
    always_comb begin
        if (!blink_en) begin
            blank_d = 1'b0;
        end else if (tick) begin
            blank_d = ~blank_q;
        end else begin
            blank_d = blank_q;
        end
    end

    // All state and outputs registered; reset discards any pending revert.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StDefault;
            sel_q      <= '0;
            cnt_q      <= '0;
            chosen_q   <= '0;
            blank_q    <= 1'b0;
            reverted_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            chosen_q   <= chosen_d;
            blank_q    <= blank_d;
            reverted_q <= reverted_d;
        end
    end

    assign chosen_time = chosen_q;
    assign cur_sel     = sel_q;
    assign blank       = blank_q;
    assign reverted    = reverted_q;

endmodule

// File: tb/tb_time_display_select.sv
// Bench for time_display_select: two instances (4 sources/TIMEOUT=10 and
// 5 sources/TIMEOUT=0) fed from shared controls, checked cycle by cycle
// against a reference model through an expected-value queue.
module tb_time_display_select;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        activity;
    logic        blink_en;
    logic        sel_valid_a;
    logic [1:0]  sel_idx_a;
    logic        sel_valid_b;
    logic [2:0]  sel_idx_b;
    logic [13:0] src [5];

    logic [4*14-1:0] src_a;
    logic [5*14-1:0] src_b;

    logic [13:0] chosen_a, chosen_b;
    logic [1:0]  cur_sel_a;
    logic [2:0]  cur_sel_b;
    logic        blank_a, blank_b;
    logic        reverted_a, reverted_b;

    assign src_a = {src[3], src[2], src[1], src[0]};
    assign src_b = {src[4], src[3], src[2], src[1], src[0]};

    time_display_select #(
        .TIME_W  (14),
        .NUM_SRC (4),
        .TIMEOUT (10)
    ) dut_a (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .src_time    (src_a),
        .sel_valid   (sel_valid_a),
        .sel_idx     (sel_idx_a),
        .activity    (activity),
        .blink_en    (blink_en),
        .chosen_time (chosen_a),
        .cur_sel     (cur_sel_a),
        .blank       (blank_a),
        .reverted    (reverted_a)
    );

    time_display_select #(
        .TIME_W  (14),
        .NUM_SRC (5),
        .TIMEOUT (0)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .src_time    (src_b),
        .sel_valid   (sel_valid_b),
        .sel_idx     (sel_idx_b),
        .activity    (activity),
        .blink_en    (blink_en),
        .chosen_time (chosen_b),
        .cur_sel     (cur_sel_b),
        .blank       (blank_b),
        .reverted    (reverted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int t;
        int s;
        int b;
        int r;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int m_alt   [2];
    int m_sel   [2];
    int m_cnt   [2];
    int m_blank [2];
    int nsrc    [2] = '{4, 5};
    int to_v    [2] = '{10, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance model k by one clock using the currently driven inputs.
    task automatic model_step(input int k, output exp_t e);
        bit v;
        int idx;
        bit legal;
        v   = (k == 0) ? sel_valid_a : sel_valid_b;
        idx = (k == 0) ? int'(sel_idx_a) : int'(sel_idx_b);
        e.r = 0;
        if (reset) begin
            m_alt[k]   = 0;
            m_sel[k]   = 0;
            m_cnt[k]   = 0;
            m_blank[k] = 0;
            e.t        = 0;
        end else begin
            legal = v && (idx < nsrc[k]);
            if (legal) begin
                m_cnt[k] = 0;
                m_sel[k] = idx;
                m_alt[k] = (idx != 0);
            end else if (m_alt[k] != 0) begin
                if (activity) begin
                    m_cnt[k] = 0;
                end else if (tick) begin
                    if (to_v[k] != 0 && m_cnt[k] + 1 >= to_v[k]) begin
                        m_alt[k] = 0;
                        m_sel[k] = 0;
                        m_cnt[k] = 0;
                        e.r      = 1;
                    end else if (m_cnt[k] < to_v[k]) begin
                        m_cnt[k]++;
                    end
                end
            end
            m_blank[k] = blink_en ? (m_blank[k] ^ int'(tick)) : 0;
            e.t        = int'(src[m_sel[k]]);
        end
        e.s = m_sel[k];
        e.b = m_blank[k];
    endtask

    // One clock: push model expectations, clock the DUTs, pop and compare.
    task automatic cycle();
        exp_t e;
        model_step(0, e);
        qa.push_back(e);
        model_step(1, e);
        qb.push_back(e);
        @(posedge clk);
        #1;
        e = qa.pop_front();
        check("a_time", 32'(chosen_a), e.t);
        check("a_sel", 32'(cur_sel_a), e.s);
        check("a_blank", 32'(blank_a), e.b);
        check("a_rev", 32'(reverted_a), e.r);
        e = qb.pop_front();
        check("b_time", 32'(chosen_b), e.t);
        check("b_sel", 32'(cur_sel_b), e.s);
        check("b_blank", 32'(blank_b), e.b);
        check("b_rev", 32'(reverted_b), e.r);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            cycle();
        end
    endtask

    task automatic select(input bit va, input int ia, input bit vb, input int ib);
        sel_valid_a = va;
        sel_idx_a   = 2'(ia);
        sel_valid_b = vb;
        sel_idx_b   = 3'(ib);
        cycle();
        sel_valid_a = 1'b0;
        sel_valid_b = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        tick        = 1'b0;
        activity    = 1'b0;
        blink_en    = 1'b0;
        sel_valid_a = 1'b0;
        sel_idx_a   = '0;
        sel_valid_b = 1'b0;
        sel_idx_b   = '0;
        for (int i = 0; i < 5; i++) src[i] = '0;
        @(negedge clk);

        // Reset state, then live tracking of source 0.
        cycle();
        cycle();
        check("rst_time", 32'(chosen_a), 0);
        check("rst_sel", 32'(cur_sel_a), 0);
        check("rst_blank", 32'(blank_a), 0);
        reset  = 1'b0;
        src[0] = 14'd1234;
        cycle();
        check("s1_1234", 32'(chosen_a), 1234);
        src[0] = 14'd1235;
        cycle();
        check("s1_1235", 32'(chosen_a), 1235);

        // Select source 1, then let dut_a time out after 10 ticks.
        src[1] = 14'd630;
        src[2] = 14'd2222;
        src[3] = 14'd3333;
        src[4] = 14'd4444;
        select(1, 1, 1, 1);
        check("s2_sel", 32'(cur_sel_a), 1);
        check("s2_time", 32'(chosen_a), 630);
        ticks(9);
        check("s2_pre", 32'(cur_sel_a), 1);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("s2_rev", 32'(reverted_a), 1);
        check("s2_sel0", 32'(cur_sel_a), 0);
        check("s2_b_stay", 32'(cur_sel_b), 1);
        cycle();
        check("s2_pulse", 32'(reverted_a), 0);
        check("s2_src0", 32'(chosen_a), 1235);

        // Activity restarts the timeout.
        select(1, 2, 1, 2);
        ticks(9);
        activity = 1'b1;
        cycle();
        activity = 1'b0;
        ticks(9);
        check("s3_norev", 32'(cur_sel_a), 2);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("s3_rev", 32'(reverted_a), 1);

        // Select on the timeout tick wins and clears the counter.
        select(1, 1, 0, 0);
        ticks(9);
        tick = 1'b1;
        select(1, 3, 0, 0);
        tick = 1'b0;
        check("s4_sel3", 32'(cur_sel_a), 3);
        check("s4_norev", 32'(reverted_a), 0);
        ticks(9);
        check("s4_cnt0", 32'(cur_sel_a), 3);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("s4_rev", 32'(reverted_a), 1);

        // Illegal indices on the 5-source instance are ignored.
        select(0, 0, 1, 5);
        check("s4_ill5", 32'(cur_sel_b), 2);
        select(0, 0, 1, 7);
        check("s4_ill7", 32'(cur_sel_b), 2);
        select(0, 0, 1, 4);
        check("s4_leg4", 32'(chosen_b), 4444);

        // Blink sequence and forced clear.
        blink_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            check("s5_blank", 32'(blank_a), (i % 2 == 0) ? 1 : 0);
            cycle();
        end
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("s5_blank_hi", 32'(blank_a), 1);
        blink_en = 1'b0;
        cycle();
        check("s5_blank_lo", 32'(blank_a), 0);
        check("s5_time", 32'(chosen_a), 1235);

        // TIMEOUT=0 never reverts; explicit return to 0; reset mid-ALT.
        ticks(100);
        check("s6_b_alt", 32'(cur_sel_b), 4);
        select(0, 0, 1, 0);
        check("s6_b_def", 32'(cur_sel_b), 0);
        check("s6_b_norev", 32'(reverted_b), 0);
        select(1, 2, 1, 3);
        ticks(3);
        reset = 1'b1;
        cycle();
        check("s6_rst_sel", 32'(cur_sel_a), 0);
        check("s6_rst_time", 32'(chosen_a), 0);
        reset = 1'b0;
        cycle();
        check("s6_src0", 32'(chosen_a), 1235);
        check("s6_b_src0", 32'(chosen_b), 1235);

        // Random mixed traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 149) == 0);
            tick        = ($urandom_range(0, 2) == 0);
            activity    = ($urandom_range(0, 7) == 0);
            sel_valid_a = ($urandom_range(0, 9) == 0);
            sel_idx_a   = 2'($urandom_range(0, 3));
            sel_valid_b = ($urandom_range(0, 9) == 0);
            sel_idx_b   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 4) == 0) src[$urandom_range(0, 4)] = 14'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
